stb_channel_switch: RTL and testbench
=====================================

// Module: stb_channel_switch
// PURPOSE
//  Parametrised N-channel ready/valid switch between the DTM host side and NUM_CH trace-buffer channels.
//  Sits between DTM_UART and the StreamTraceBuffer instances; replaces the fixed two-channel port set.
//  Carries one downstream stream (host->channel) and one upstream stream (channel->host), each through a 2-entry skid buffer.
//  The host changes the active channel with a select handshake. The switch applies it only after in-flight beats drain, so no beat is misrouted.
// PARAMETERS
//  NUM_CH      2   number of channels, >=2; SW = $clog2(NUM_CH) (localparam)
//  DOWN_WIDTH  32  downstream payload width (host->channel)
//  UP_WIDTH    32  upstream payload width (channel->host)
// PORTS
//  CLK_I           in   1               clock
//  RST_NI          in   1               asynchronous active-low reset
//  SEL_VALID_I     in   1               channel-select request valid
//  SEL_I           in   SW              requested channel index
//  SEL_READY_O     out  1               select accepted (1-cycle pulse)
//  SEL_ERR_O       out  1               1-cycle pulse: accepted SEL_I was >= NUM_CH
//  ACTIVE_O        out  SW              currently active channel
//  DOWN_VALID_I    in   1               host downstream valid
//  DOWN_READY_O    out  1               host downstream ready
//  DOWN_I          in   DOWN_WIDTH      host downstream payload
//  CH_DOWN_VALID_O out  NUM_CH          per-channel downstream valid (one-hot or zero)
//  CH_DOWN_READY_I in   NUM_CH          per-channel downstream ready
//  CH_DOWN_O       out  DOWN_WIDTH      downstream payload (shared by all channels)
//  UP_VALID_O      out  1               host upstream valid
//  UP_READY_I      in   1               host upstream ready
//  UP_O            out  UP_WIDTH        host upstream payload
//  CH_UP_VALID_I   in   NUM_CH          per-channel upstream valid
//  CH_UP_READY_O   out  NUM_CH          per-channel upstream ready (one-hot or zero)
//  CH_UP_I         in   NUM_CH*UP_WIDTH channel c payload at [c*UP_WIDTH +: UP_WIDTH]
// BEHAVIOUR
//  Reset (async, RST_NI=0):
//   - active=0, both buffers empty, FSM=ACTIVE.
//   - All outputs 0: SEL_READY_O, SEL_ERR_O, ACTIVE_O, valids, readies, payloads.
//   - Reset asserted mid-transfer discards buffered beats.
//  Skid buffer (one per direction):
//   - 2 entries, count 0..2; in-ready = (count<2) && accept_en; out-valid = (count>0).
//   - Output is driven from the head register, so latency is 1 cycle from input accept to output valid.
//   - Throughput is 1 beat/cycle. A simultaneous push and pop leaves count unchanged. Order is FIFO.
//  Routing (c = active channel):
//   - CH_DOWN_VALID_O[c] = down-buffer valid; all other bits 0.
//   - The down buffer pops on CH_DOWN_READY_I[c].
//   - CH_UP_READY_O[c] = up-buffer in-ready; all other bits 0. Non-active CH_UP_VALID_I is ignored.
//  FSM states:
//   - ACTIVE: accept_en=1. SEL_VALID_I=1 -> DRAIN.
//   - DRAIN: accept_en=0, so DOWN_READY_O=0 and CH_UP_READY_O=0. Both buffers keep emitting.
//     * SEL_VALID_I drops -> ACTIVE (request abandoned).
//     * Both buffers empty -> SWITCH.
//   - SWITCH (1 cycle): accept_en=0; SEL_READY_O=1.
//     * SEL_I<NUM_CH: active<=SEL_I.
//     * Otherwise active is unchanged and SEL_ERR_O=1.
//     * Next state is ACTIVE.
//  Timing and corner cases:
//   - ACTIVE_O updates in the cycle after SWITCH. The first beat on the new channel is accepted at the earliest then.
//   - Selecting the already-active channel still runs DRAIN/SWITCH; it is harmless.
//   - If a buffer already holds a beat in the request cycle, that beat is delivered to the old channel before the switch.
//   - Stalled channel (CH_DOWN_READY_I[c]=0 forever): DRAIN does not exit. The host resolves this by dropping SEL_VALID_I.
// TESTING
//  1. Reset, then 8 back-to-back DOWN beats 0x1..0x8 with CH_DOWN_READY_I=2'b01
//     -> ch0 receives all 8 in order at 1/cycle, first one 1 cycle after accept; CH_DOWN_VALID_O[1]=0 throughout.
//  2. Toggle UP_READY_I (1,0,1,0) while ch0 streams 0xA0..0xA7
//     -> no loss or duplication; CH_UP_READY_O[0] falls only when count=2.
//  3. Select SEL_I=1 while the down buffer holds 2 beats and CH_DOWN_READY_I[0]=1
//     -> both beats reach ch0; then SEL_READY_O pulses; ACTIVE_O=1; the next beat goes to ch1.
//  4. NUM_CH=3, SEL_I=3
//     -> SEL_READY_O=1 and SEL_ERR_O=1 for one cycle; ACTIVE_O unchanged; traffic resumes.
//  5. Drop SEL_VALID_I during DRAIN while CH_DOWN_READY_I[0]=0
//     -> FSM returns to ACTIVE; DOWN_READY_O reasserts next cycle; no select pulse.
//  6. Assert RST_NI=0 mid-burst with 2 beats buffered
//     -> all valids 0 immediately (async); ACTIVE_O=0; no stale beat after release.

Source files
------------

// File: rtl/stb_channel_switch.sv
// stb_channel_switch
//   N-channel ready/valid switch between the DTM host side and NUM_CH
//   trace-buffer channels. One downstream stream (host -> channel) and one
//   upstream stream (channel -> host), each through a 2-entry skid buffer
//   whose head register drives the output directly.
//   The host moves the active channel with a select handshake. The switch
//   stops accepting new beats, lets both buffers drain to the old channel,
//   and only then changes the route, so no beat is ever misrouted.
// Ports
//   CLK_I / RST_NI      clock, asynchronous active-low reset
//   SEL_VALID_I/SEL_I   select request and requested channel index
//   SEL_READY_O         1-cycle pulse when a select is applied
//   SEL_ERR_O           1-cycle pulse alongside SEL_READY_O if SEL_I >= NUM_CH
//   ACTIVE_O            currently active channel
//   DOWN_*              host downstream ready/valid/payload
//   CH_DOWN_*           per-channel downstream valid/ready, shared payload
//   UP_*                host upstream ready/valid/payload
//   CH_UP_*             per-channel upstream valid/ready, packed payloads
module stb_channel_switch #(
  parameter  int NUM_CH     = 2,
  parameter  int DOWN_WIDTH = 32,
  parameter  int UP_WIDTH   = 32,
  localparam int SW         = $clog2(NUM_CH)
) (
  input  logic                       CLK_I,
  input  logic                       RST_NI,
  input  logic                       SEL_VALID_I,
  input  logic [SW-1:0]              SEL_I,
  output logic                       SEL_READY_O,
  output logic                       SEL_ERR_O,
  output logic [SW-1:0]              ACTIVE_O,
  input  logic                       DOWN_VALID_I,
  output logic                       DOWN_READY_O,
  input  logic [DOWN_WIDTH-1:0]      DOWN_I,
  output logic [NUM_CH-1:0]          CH_DOWN_VALID_O,
  input  logic [NUM_CH-1:0]          CH_DOWN_READY_I,
  output logic [DOWN_WIDTH-1:0]      CH_DOWN_O,
  output logic                       UP_VALID_O,
  input  logic                       UP_READY_I,
  output logic [UP_WIDTH-1:0]        UP_O,
  input  logic [NUM_CH-1:0]          CH_UP_VALID_I,
  output logic [NUM_CH-1:0]          CH_UP_READY_O,
  input  logic [NUM_CH*UP_WIDTH-1:0] CH_UP_I
);

  localparam logic [SW:0] NUM_CH_W = (SW+1)'(NUM_CH);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         active_q, active_d;
  // Low for the first cycle after reset so every ready output is 0 in reset.
  logic                  run_q;

  logic [1:0]            dn_cnt_q, dn_cnt_d;
  logic [DOWN_WIDTH-1:0] dn_head_q, dn_head_d;
  logic [DOWN_WIDTH-1:0] dn_tail_q, dn_tail_d;
  logic [1:0]            up_cnt_q, up_cnt_d;
  logic [UP_WIDTH-1:0]   up_head_q, up_head_d;
  logic [UP_WIDTH-1:0]   up_tail_q, up_tail_d;

  logic                  accept_en_s;
  logic                  dn_in_rdy_s, dn_push_s, dn_pop_s;
  logic                  up_in_rdy_s, up_push_s, up_pop_s;
  logic                  ch_dn_rdy_s, ch_up_vld_s;
  logic [UP_WIDTH-1:0]   ch_up_data_s;
  logic [NUM_CH-1:0]     ch_dn_vld_s, ch_up_rdy_s;
  logic                  sel_ready_s, sel_err_s;

  // Channel routing: pick the active channel's ready/valid/payload and fan out.
  always_comb begin
    accept_en_s  = run_q && (state_q == ST_ACTIVE);
    dn_in_rdy_s  = (dn_cnt_q != 2'd2) && accept_en_s;
    up_in_rdy_s  = (up_cnt_q != 2'd2) && accept_en_s;
    ch_dn_rdy_s  = 1'b0;
    ch_up_vld_s  = 1'b0;
    ch_up_data_s = {UP_WIDTH{1'b0}};
    ch_dn_vld_s  = {NUM_CH{1'b0}};
    ch_up_rdy_s  = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      ch_dn_rdy_s    = ch_dn_rdy_s | (CH_DOWN_READY_I[c] & (active_q == SW'(c)));
      ch_up_vld_s    = ch_up_vld_s | (CH_UP_VALID_I[c] & (active_q == SW'(c)));
      ch_up_data_s   = ch_up_data_s |
                       (CH_UP_I[c*UP_WIDTH +: UP_WIDTH] & {UP_WIDTH{active_q == SW'(c)}});
      ch_dn_vld_s[c] = (dn_cnt_q != 2'd0) && (active_q == SW'(c));
      ch_up_rdy_s[c] = up_in_rdy_s && (active_q == SW'(c));
    end
    dn_push_s = DOWN_VALID_I && dn_in_rdy_s;
    dn_pop_s  = (dn_cnt_q != 2'd0) && ch_dn_rdy_s;
    up_push_s = ch_up_vld_s && up_in_rdy_s;
    up_pop_s  = (up_cnt_q != 2'd0) && UP_READY_I;
  end

  // Downstream skid buffer: head feeds the output, tail catches the overflow.
  always_comb begin
    dn_cnt_d  = dn_cnt_q;
    dn_head_d = dn_head_q;
    dn_tail_d = dn_tail_q;
    case ({dn_push_s, dn_pop_s})
      2'b10: begin
        if (dn_cnt_q == 2'd0) dn_head_d = DOWN_I;
        else                  dn_tail_d = DOWN_I;
        dn_cnt_d = dn_cnt_q + 2'd1;
      end
      2'b01: begin
        dn_head_d = dn_tail_q;
        dn_cnt_d  = dn_cnt_q - 2'd1;
      end
      2'b11: begin
        // Push requires count<2 and pop requires count>0, so count is 1 here.
        if (dn_cnt_q == 2'd1) begin
          dn_head_d = DOWN_I;
        end else begin
          dn_head_d = dn_tail_q;
          dn_tail_d = DOWN_I;
        end
      end
      default: dn_cnt_d = dn_cnt_q;
    endcase
  end

  // Upstream skid buffer, same structure as the downstream one.
  always_comb begin
    up_cnt_d  = up_cnt_q;
    up_head_d = up_head_q;
    up_tail_d = up_tail_q;
    case ({up_push_s, up_pop_s})
      2'b10: begin
        if (up_cnt_q == 2'd0) up_head_d = ch_up_data_s;
        else                  up_tail_d = ch_up_data_s;
        up_cnt_d = up_cnt_q + 2'd1;
      end
      2'b01: begin
        up_head_d = up_tail_q;
        up_cnt_d  = up_cnt_q - 2'd1;
      end
      2'b11: begin
        if (up_cnt_q == 2'd1) begin
          up_head_d = ch_up_data_s;
        end else begin
          up_head_d = up_tail_q;
          up_tail_d = ch_up_data_s;
        end
      end
      default: up_cnt_d = up_cnt_q;
    endcase
  end

  // Select FSM: block intake, wait for both buffers to empty, then retarget.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    sel_ready_s = 1'b0;
    sel_err_s   = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (SEL_VALID_I) state_d = ST_DRAIN;
        else             state_d = ST_ACTIVE;
      end
      ST_DRAIN: begin
        // Abandonment wins over completion so a stalled channel can be escaped.
        if (!SEL_VALID_I)                                  state_d = ST_ACTIVE;
        else if ((dn_cnt_q == 2'd0) && (up_cnt_q == 2'd0)) state_d = ST_SWITCH;
        else                                               state_d = ST_DRAIN;
      end
      ST_SWITCH: begin
        sel_ready_s = 1'b1;
        if ({1'b0, SEL_I} < NUM_CH_W) active_d  = SEL_I;
        else                          sel_err_s = 1'b1;
        state_d = ST_ACTIVE;
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // State, route and buffer registers; reset discards any buffered beats.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q   <= ST_ACTIVE;
      active_q  <= {SW{1'b0}};
      run_q     <= 1'b0;
      dn_cnt_q  <= 2'd0;
      dn_head_q <= {DOWN_WIDTH{1'b0}};
      dn_tail_q <= {DOWN_WIDTH{1'b0}};
      up_cnt_q  <= 2'd0;
      up_head_q <= {UP_WIDTH{1'b0}};
      up_tail_q <= {UP_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      run_q     <= 1'b1;
      dn_cnt_q  <= dn_cnt_d;
      dn_head_q <= dn_head_d;
      dn_tail_q <= dn_tail_d;
      up_cnt_q  <= up_cnt_d;
      up_head_q <= up_head_d;
      up_tail_q <= up_tail_d;
    end
  end

  assign SEL_READY_O     = sel_ready_s;
  assign SEL_ERR_O       = sel_err_s;
  assign ACTIVE_O        = active_q;
  assign DOWN_READY_O    = dn_in_rdy_s;
  assign CH_DOWN_VALID_O = ch_dn_vld_s;
  assign CH_DOWN_O       = dn_head_q;
  assign UP_VALID_O      = (up_cnt_q != 2'd0);
  assign UP_O            = up_head_q;
  assign CH_UP_READY_O   = ch_up_rdy_s;

endmodule

// File: tb/tb_stb_channel_switch.sv
// Testbench for stb_channel_switch with NUM_CH=3 (so an out-of-range select
// index exists). A queue-based model tracks which channel every beat belongs
// to and is compared against the DUT outputs on every falling clock edge.
module tb_stb_channel_switch;
  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel_valid = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        sel_ready, sel_err;
  logic [1:0]  active;
  logic        down_valid = 1'b0;
  logic        down_ready;
  logic [31:0] down_data;
  logic [2:0]  ch_down_valid;
  logic [2:0]  ch_down_ready = 3'b000;
  logic [31:0] ch_down;
  logic        up_valid;
  logic        up_ready = 1'b0;
  logic [31:0] up_data;
  logic [2:0]  ch_up_valid = 3'b000;
  logic [2:0]  ch_up_ready;
  logic [95:0] ch_up;

  logic [31:0] d_next;
  logic [31:0] u_next [3];
  logic [31:0] u_init [3];
  assign down_data = d_next;
  assign ch_up = {u_next[2], u_next[1], u_next[0]};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_sel_rdy = 0;
  int n_sel_err = 0;
  bit chk_en = 1'b1;
  bit dfire, sel_seen;
  bit [2:0] ufire;

  stb_channel_switch #(.NUM_CH(NCH), .DOWN_WIDTH(32), .UP_WIDTH(32)) dut (
    .CLK_I(clk), .RST_NI(rst_n),
    .SEL_VALID_I(sel_valid), .SEL_I(sel), .SEL_READY_O(sel_ready),
    .SEL_ERR_O(sel_err), .ACTIVE_O(active),
    .DOWN_VALID_I(down_valid), .DOWN_READY_O(down_ready), .DOWN_I(down_data),
    .CH_DOWN_VALID_O(ch_down_valid), .CH_DOWN_READY_I(ch_down_ready), .CH_DOWN_O(ch_down),
    .UP_VALID_O(up_valid), .UP_READY_I(up_ready), .UP_O(up_data),
    .CH_UP_VALID_I(ch_up_valid), .CH_UP_READY_O(ch_up_ready), .CH_UP_I(ch_up)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {logic [31:0] d; int ch;} beat_t;
  typedef struct {logic [31:0] d; int ch; int cyc;} rx_t;
  beat_t       mdq[$];
  logic [31:0] muq[$];
  int          m_active = 0;
  int          m_phase = 0;   // 0: accepting, 1: waiting for drain, 2: switching
  bit          m_run = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    bit acc, popd, pushd, popu, pushu;
    int nphase, nact;
    logic [31:0] ud;
    if (!rst_n) begin
      mdq.delete(); muq.delete();
      m_active = 0; m_phase = 0; m_run = 1'b0;
    end else begin
      acc   = m_run && (m_phase == 0);
      popd  = (mdq.size() > 0) ? ch_down_ready[mdq[0].ch] : 1'b0;
      pushd = acc && (mdq.size() < 2) && down_valid;
      popu  = (muq.size() > 0) && up_ready;
      pushu = acc && (muq.size() < 2) && ch_up_valid[m_active];
      ud    = ch_up[m_active*32 +: 32];
      nphase = m_phase; nact = m_active;
      if (m_phase == 0) begin
        if (sel_valid) nphase = 1;
      end else if (m_phase == 1) begin
        if (!sel_valid) nphase = 0;
        else if (mdq.size() == 0 && muq.size() == 0) nphase = 2;
      end else begin
        if (int'(sel) < NCH) nact = int'(sel);
        nphase = 0;
      end
      if (popd) void'(mdq.pop_front());
      if (pushd) mdq.push_back('{down_data, m_active});
      if (popu) void'(muq.pop_front());
      if (pushu) muq.push_back(ud);
      m_phase = nphase; m_active = nact; m_run = 1'b1;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sel_ready", sel_ready, m_phase == 2);
      chk("sel_err", sel_err, (m_phase == 2) && (int'(sel) >= NCH));
      chk("active", active, m_active);
      chk("down_ready", down_ready, m_run && m_phase == 0 && mdq.size() < 2);
      chk("ch_down_valid", ch_down_valid, (mdq.size() > 0) ? (3'b001 << mdq[0].ch) : 3'b000);
      if (mdq.size() > 0) chk("ch_down", ch_down, mdq[0].d);
      else if (!rst_n)    chk("ch_down_rst", ch_down, 0);
      chk("up_valid", up_valid, muq.size() > 0);
      if (muq.size() > 0) chk("up_data", up_data, muq[0]);
      else if (!rst_n)    chk("up_data_rst", up_data, 0);
      chk("ch_up_ready", ch_up_ready,
          (m_run && m_phase == 0 && muq.size() < 2) ? (3'b001 << m_active) : 3'b000);
      if (sel_ready) n_sel_rdy++;
      if (sel_err) n_sel_err++;
    end
  end

  // Receivers: log every completed handshake on the channel and host sides.
  rx_t         rx_down[$];
  logic [31:0] rx_up[$];
  always @(posedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NCH; c++)
        if (ch_down_valid[c] && ch_down_ready[c]) rx_down.push_back('{ch_down, c, cyc});
      if (up_valid && up_ready) rx_up.push_back(up_data);
    end
  end

  task automatic step();
    @(negedge clk);
    dfire = down_valid && down_ready;
    for (int c = 0; c < NCH; c++) ufire[c] = ch_up_valid[c] && ch_up_ready[c];
    sel_seen = sel_ready;
    @(posedge clk);
    #1;
    if (dfire) d_next = d_next + 32'd1;
    for (int c = 0; c < NCH; c++) if (ufire[c]) u_next[c] = u_next[c] + 32'd1;
    cyc++;
  endtask

  task automatic send_down(logic [31:0] until_next);
    down_valid = 1'b1;
    for (int i = 0; i < 40 && d_next != until_next; i++) step();
    down_valid = 1'b0;
    chk("send_down_timeout", d_next, until_next);
  endtask

  task automatic do_select(logic [1:0] s);
    sel = s; sel_valid = 1'b1; sel_seen = 1'b0;
    for (int i = 0; i < 40 && !sel_seen; i++) step();
    sel_valid = 1'b0;
    chk("sel_handshake", sel_seen, 1);
  endtask

  initial begin : stim
    int n0, sum_up;
    d_next = 32'd1;
    u_next[0] = 32'hA0; u_next[1] = 32'h100; u_next[2] = 32'h200;
    for (int c = 0; c < NCH; c++) u_init[c] = u_next[c];

    // Reset state
    repeat (2) step();
    chk("rst_active", active, 0);
    chk("rst_down_ready", down_ready, 0);
    chk("rst_ch_up_ready", ch_up_ready, 0);
    rst_n = 1'b1;
    step();

    // 1: eight back-to-back downstream beats to ch0
    ch_down_ready = 3'b001;
    send_down(32'd9);
    repeat (4) step();
    chk("t1_count", rx_down.size(), 8);
    for (int i = 0; i < 8 && i < rx_down.size(); i++) begin
      chk("t1_data", rx_down[i].d, i + 1);
      chk("t1_chan", rx_down[i].ch, 0);
    end
    if (rx_down.size() == 8) chk("t1_rate", rx_down[7].cyc - rx_down[0].cyc, 7);

    // 2: ch0 upstream 0xA0..0xA7 with toggling host ready
    ch_up_valid = 3'b001; up_ready = 1'b1;
    for (int i = 0; i < 60 && rx_up.size() < 8; i++) begin
      if (u_next[0] == 32'hA8) ch_up_valid = 3'b000;
      step();
      up_ready = ~up_ready;
    end
    ch_up_valid = 3'b000; up_ready = 1'b1;
    step();
    chk("t2_count", rx_up.size(), 8);
    for (int i = 0; i < 8 && i < rx_up.size(); i++) chk("t2_data", rx_up[i], 32'hA0 + i);

    // 3: switch to ch1 with two beats waiting for ch0
    ch_down_ready = 3'b000;
    send_down(32'd11);
    ch_down_ready = 3'b001;
    do_select(2'd1);
    ch_down_ready = 3'b010;
    step();
    chk("t3_active", active, 1);
    send_down(32'd12);
    repeat (3) step();
    chk("t3_count", rx_down.size(), 11);
    if (rx_down.size() == 11) begin
      chk("t3_b9", {rx_down[8].d, rx_down[8].ch[31:0]}, {32'd9, 32'd0});
      chk("t3_b10", {rx_down[9].d, rx_down[9].ch[31:0]}, {32'd10, 32'd0});
      chk("t3_b11", {rx_down[10].d, rx_down[10].ch[31:0]}, {32'd11, 32'd1});
    end

    // 4: out-of-range select
    n0 = n_sel_err;
    do_select(2'd3);
    step();
    chk("t4_err_pulses", n_sel_err - n0, 1);
    chk("t4_active", active, 1);
    send_down(32'd13);
    repeat (3) step();
    chk("t4_resume", {rx_down[rx_down.size()-1].d, rx_down[rx_down.size()-1].ch[31:0]},
        {32'd12, 32'd1});

    // 5: abandon a select while the active channel is stalled
    ch_down_ready = 3'b000;
    send_down(32'd14);
    n0 = n_sel_rdy;
    sel = 2'd0; sel_valid = 1'b1;
    step();
    chk("t5_drain_ready", down_ready, 0);
    repeat (2) step();
    sel_valid = 1'b0;
    step();
    chk("t5_ready_back", down_ready, 1);
    chk("t5_no_pulse", n_sel_rdy - n0, 0);
    ch_down_ready = 3'b010;
    repeat (3) step();

    // Randomised traffic with random selects and abandonments
    for (int i = 0; i < 3000; i++) begin
      down_valid    = 1'($urandom_range(0, 1));
      ch_down_ready = 3'($urandom_range(0, 7));
      ch_up_valid   = 3'($urandom_range(0, 7));
      up_ready      = 1'($urandom_range(0, 1));
      if (sel_valid) begin
        if (sel_seen || $urandom_range(0, 31) == 0) sel_valid = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        sel = 2'($urandom_range(0, 3));
        sel_valid = 1'b1;
      end
      step();
    end
    down_valid = 1'b0; ch_up_valid = 3'b000; sel_valid = 1'b0;
    ch_down_ready = 3'b111; up_ready = 1'b1;
    repeat (8) step();
    chk("rand_down_conserved", rx_down.size(), d_next - 32'd1);
    sum_up = 0;
    for (int c = 0; c < NCH; c++) sum_up += int'(u_next[c] - u_init[c]);
    chk("rand_up_conserved", rx_up.size(), sum_up);

    // 6: asynchronous reset with two beats buffered
    ch_down_ready = 3'b000;
    send_down(d_next + 32'd2);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_async", {ch_down_valid, up_valid}, 4'b0000);
    chk("t6_active_async", active, 0);
    step(); step();
    rst_n = 1'b1;
    ch_down_ready = 3'b111;
    n0 = rx_down.size();
    repeat (5) step();
    chk("t6_no_stale", rx_down.size(), n0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
